// File: rtl/alu_cond_stage_pkg.sv
// Shared ARM condition-field encodings and NZCV flag bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_stage_cond_check.sv
// Combinational evaluation of an ARM condition field against stored NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       cpass
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cpass = 1'b0;
    case (cond_t'(Cond))
      COND_EQ: cpass = z;
      COND_NE: cpass = ~z;
      COND_CS: cpass = c;
      COND_CC: cpass = ~c;
      COND_MI: cpass = n;
      COND_PL: cpass = ~n;
      COND_VS: cpass = v;
      COND_VC: cpass = ~v;
      COND_HI: cpass = c & ~z;
      COND_LS: cpass = ~c | z;
      COND_GE: cpass = (n == v);
      COND_LT: cpass = (n != v);
      COND_GT: cpass = ~z & (n == v);
      COND_LE: cpass = z | (n != v);
      COND_AL: cpass = 1'b1;
      default: cpass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cond_stage.sv
// ALU result register, NZCV flag register and condition-gated write enables.
// Optional COND_STATS_EN adds saturating executed/skipped instruction counters.
module alu_cond_stage
  import arm_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [3:0]       ALUFlags,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic             CondLatch,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite
`ifdef COND_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] ExecCount,
  output logic [CNT_WIDTH-1:0] SkipCount
`endif
);

  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q, flags_d;
  logic             cond_ex_q, cond_ex_d;
  logic             cpass;

  cond_check u_cond_check (
    .Cond  (Cond),
    .Flags (flags_q),
    .cpass (cpass)
  );

  // A failed condition blocks both flag groups; ALUFlags is never sampled when not selected.
  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && cpass) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    if (FlagW[0] && cpass) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
    cond_ex_d = CondLatch ? cpass : cond_ex_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      alu_out_q <= '0;
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      alu_out_q <= ALUResult;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign ALUOut   = alu_out_q;
  assign Flags    = flags_q;
  assign CondEx   = cond_ex_q;
  assign PCWrite  = NextPC | (PCS & cond_ex_q);
  assign RegWrite = RegW & cond_ex_q & ~NoWrite;
  assign MemWrite = MemW & cond_ex_q;

`ifdef COND_STATS_EN
  logic [CNT_WIDTH-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_WIDTH-1:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (CondLatch) begin
      if (cpass) begin
        if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + 1'b1;
      end else begin
        if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign ExecCount = exec_cnt_q;
  assign SkipCount = skip_cnt_q;
`endif

endmodule

// File: doc/alu_cond_stage.md
Name: alu_cond_stage

Overview:
- Stage directly downstream of the ALU in the multicycle ARM datapath.
- Registers the ALU result into ALUOut and holds the NZCV flag register.
- Evaluates the instruction condition field against the stored flags.
- Gates PC, register-file and memory writes with a latched condition-pass bit.

Parameters:
WIDTH, 32, datapath width of ALUResult/ALUOut
CNT_WIDTH, 32, width of the statistics counters (used only with COND_STATS_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
ALUResult  input  WIDTH  ALU result for the current cycle
ALUFlags  input  4  ALU flags {N,Z,C,V}
Cond  input  4  instruction condition field
FlagW  input  2  flag write request; [1]=N,Z group, [0]=C,V group
CondLatch  input  1  strobe from the controller in the execute state; captures the condition-pass bit
PCS  input  1  instruction writes the PC
NextPC  input  1  unconditional PC increment request from the controller
RegW  input  1  register write request
MemW  input  1  memory write request
NoWrite  input  1  suppress the register write (CMP/TST)
ALUOut  output  WIDTH  registered ALU result
Flags  output  4  registered {N,Z,C,V}
CondEx  output  1  latched condition-pass bit
PCWrite  output  1  gated PC write enable
RegWrite  output  1  gated register write enable
MemWrite  output  1  gated memory write enable

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset state: ALUOut=0, Flags=4'b0000, CondEx=0. Therefore PCWrite=NextPC, RegWrite=0 and MemWrite=0 while held in reset.
- ALUOut: ALUOut<=ALUResult on every non-reset edge. One cycle latency, no enable.
- Condition check: combinational pass bit cpass, computed from Cond and the registered Flags:
  - EQ=Z, NE=~Z, CS=C, CC=~C, MI=N, PL=~N, VS=V, VC=~V
  - HI=C&~Z, LS=~C|Z
  - GE=(N==V), LT=(N!=V), GT=~Z&(N==V), LE=Z|(N!=V)
  - AL(1110)=1
  - 1111=0 (never executes)
- Flag update:
  - If FlagW[1]&cpass, Flags[3:2]<=ALUFlags[3:2].
  - If FlagW[0]&cpass, Flags[1:0]<=ALUFlags[1:0].
  - The two groups are independent. A failed condition leaves both groups unchanged.
- CondEx: CondEx<=cpass when CondLatch=1; otherwise it holds its value.
- CondLatch and FlagW in the same cycle: cpass uses the pre-update Flags, and both registers load at the same edge.
- Write gating (combinational from registered state and request inputs):
  - PCWrite=NextPC|(PCS&CondEx)
  - RegWrite=RegW&CondEx&~NoWrite
  - MemWrite=MemW&CondEx
- Reset asserted mid-instruction: all state clears at that edge and any pending write is dropped. The next CondLatch re-evaluates against Flags=0.
- ALUFlags don't-care values are ignored unless written. X on ALUFlags with FlagW=0 must not propagate into Flags.

Optional Feature:
COND_STATS_EN
- Defined:
  - Adds ports ExecCount (output, CNT_WIDTH) and SkipCount (output, CNT_WIDTH).
  - On each CondLatch edge, ExecCount increments if cpass=1, otherwise SkipCount increments.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package arm_pkg:
  - cond_t enum with the 16 condition encodings
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One natural sub-module: cond_check, purely combinational (Cond, Flags -> cpass).
- Registers, gating and counters stay in alu_cond_stage.

Test Plan:
1. Reset: assert reset for 2 cycles with ALUResult=32'hDEADBEEF -> ALUOut=0, Flags=0, CondEx=0, RegWrite=0, MemWrite=0; PCWrite follows NextPC.
2. Flag write: Cond=AL, FlagW=2'b11, ALUFlags=4'b0110 -> Flags=4'b0110 next cycle. Then Cond=EQ with CondLatch -> CondEx=1; RegW=1 -> RegWrite=1.
3. Failed condition: Flags=4'b0100, Cond=NE, FlagW=2'b11, ALUFlags=4'b1001, CondLatch=1 -> Flags stay 4'b0100, CondEx=0; MemW=1 -> MemWrite=0.
4. Partial flag write: Flags=4'b0000, Cond=AL, FlagW=2'b10, ALUFlags=4'b1111 -> Flags=4'b1100 (C,V untouched).
5. Signed conditions sweep: Flags {N,V}=10 -> GE=0, LT=1, GT=0, LE=1. Flags {N,V}=11 with Z=0 -> GT=1. Cond=1111 -> CondEx=0 for every Flags value.
6. COND_STATS_EN: 3 passing and 2 failing CondLatch pulses -> ExecCount=3, SkipCount=2. With CNT_WIDTH=4, 20 passing pulses -> ExecCount=4'hF (saturated).
